// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-input round-robin arbiter: the ownership
// state encoding and the default payload width / burst-hold limit.
package mux2_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arbState_e;

   localparam int DEF_DATA_W   = 2;
   localparam int DEF_HOLD_MAX = 4;

   // True when the given ownership state routes requester A to the output.
   function automatic logic ownerIsA(arbState_e s);
      return (s == OWN_A);
   endfunction

endpackage

// File: rtl/arb_mux2.sv
// Registered 2:1 payload selector used by mux2_arbiter. The select always
// comes from decoded arbiter state, so the two payloads are never blended.
module arb_mux2 #(
   parameter int DATA_W = mux2_arb_pkg::DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              load,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   output logic [DATA_W-1:0] out_data
);

   logic [DATA_W-1:0] data_q;

   // Capture the selected payload only when a new beat is accepted; otherwise
   // keep the held value so a stalled or idle output stays stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (load) begin
         if (sel) begin
            data_q <= a_data;
         end else begin
            data_q <= b_data;
         end
      end
   end

   assign out_data = data_q;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output beat.
// Optional macro ARB_BURST_LOCK_EN lets the current owner keep the grant for
// up to HOLD_MAX consecutive beats while it stays valid; without it the
// grant alternates per beat under contention.
module mux2_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int HOLD_MAX = DEF_HOLD_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   input  logic              out_ready
);

   localparam int CNT_W = $clog2(HOLD_MAX + 1);

   arbState_e          state_q;
   arbState_e          state_d;
   arbState_e          nextOwner;
   logic               lastA_q;
   logic               lastA_d;
   logic [CNT_W-1:0]   holdCnt_q;
   logic [CNT_W-1:0]   holdCnt_d;
   logic               outValid_q;
   logic               outValid_d;
   logic               outSrc_q;
   logic               outSrc_d;
   logic               load;
   logic               grantA;
   logic               grantB;
   logic               beat;
   logic               holdReached;

   // The output register can take a beat when empty or being drained.
   assign load        = !outValid_q | out_ready;
   assign holdReached = (holdCnt_q >= CNT_W'(HOLD_MAX));

   // Choose who would own the next beat. Round-robin under contention, with
   // last-served starting at B so A wins the first tie. With burst lock, a
   // still-valid owner below its hold limit keeps the grant.
   always_comb begin
      nextOwner = IDLE;
      if (a_valid && b_valid) begin
         nextOwner = lastA_q ? OWN_B : OWN_A;
      end else if (a_valid) begin
         nextOwner = OWN_A;
      end else if (b_valid) begin
         nextOwner = OWN_B;
      end
`ifdef ARB_BURST_LOCK_EN
      if (state_q == OWN_A && a_valid && !holdReached) begin
         nextOwner = OWN_A;
      end else if (state_q == OWN_B && b_valid && !holdReached) begin
         nextOwner = OWN_B;
      end
`endif
   end

   // Grants follow the decoded next owner and are suppressed while stalled
   // or in reset, so at most one ready is ever high.
   always_comb begin
      grantA  = ownerIsA(nextOwner);
      grantB  = (nextOwner == OWN_B);
      a_ready = load & grantA & !rst;
      b_ready = load & grantB & !rst;
      beat    = load & (grantA | grantB);
   end

   // Next-state for ownership, last-served, hold counter and output flags.
   // Everything holds during a stall; an idle load empties the output and
   // returns ownership to IDLE.
   always_comb begin
      state_d    = state_q;
      lastA_d    = lastA_q;
      holdCnt_d  = holdCnt_q;
      outValid_d = outValid_q;
      outSrc_d   = outSrc_q;
      if (load) begin
         state_d    = nextOwner;
         outValid_d = beat;
         if (beat) begin
            lastA_d  = grantA;
            outSrc_d = grantA;
            if (nextOwner != state_q || holdReached) begin
               holdCnt_d = CNT_W'(1);
            end else begin
               holdCnt_d = holdCnt_q + CNT_W'(1);
            end
         end else begin
            holdCnt_d = '0;
         end
      end
   end

   // State registers with synchronous reset; a reset also drops a held beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lastA_q    <= 1'b0;
         holdCnt_q  <= '0;
         outValid_q <= 1'b0;
         outSrc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lastA_q    <= lastA_d;
         holdCnt_q  <= holdCnt_d;
         outValid_q <= outValid_d;
         outSrc_q   <= outSrc_d;
      end
   end

   arb_mux2 #(
      .DATA_W (DATA_W)
   ) uMux (
      .clk      (clk),
      .rst      (rst),
      .sel      (grantA),
      .load     (beat),
      .a_data   (a_data),
      .b_data   (b_data),
      .out_data (out_data)
   );

   assign out_valid = outValid_q;
   assign out_src   = outSrc_q;

endmodule
